// File: rtl/smi_pkg.sv
// Shared definitions for the Clause-22 SMI (MDIO) responder: FSM state
// encoding, opcode constants and frame field widths.
package smi_pkg;

  typedef enum logic [3:0] {
    S_PRE,
    S_ST,
    S_OP,
    S_PHYAD,
    S_REGAD,
    S_TA,
    S_WDATA,
    S_RDATA,
    S_SKIP
  } smi_state_e;

  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_WRITE = 2'b01;

  localparam int PHY_W     = 5;
  localparam int REG_W     = 5;
  localparam int DATA_W    = 16;
  localparam int TA_BITS   = 2;
  localparam int SKIP_BITS = TA_BITS + DATA_W;
  localparam int BCNT_W    = 5;

endpackage

// File: rtl/smi_sync_edge.sv
// Two-flop synchroniser for an asynchronous pad signal with rising/falling
// edge detection on the synchronised value. All flops reset to 1, the
// idle level of both MDC-high-default and MDIO pull-up.
module smi_sync_edge (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic s1_q;
  logic s2_q;
  logic prev_q;

  // Synchroniser chain plus one history flop for edge detection
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      s1_q   <= d_i;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end

  assign q_o    = s2_q;
  assign rise_o = s2_q & ~prev_q;
  assign fall_o = ~s2_q & prev_q;

endmodule

// File: rtl/smi_responder.sv
// Clause-22 SMI responder (MDIO slave). Oversamples MDC/MDIO with clk_i,
// samples MDIO on MDC rising edges and updates the pad drive on MDC
// falling edges. Register accesses are exposed as single-cycle strobes.
// Optional build macro SMI_RESP_PRE_SUPPRESS_EN: accept ST after any
// single preamble one (preamble suppression) instead of PREAMBLE_LEN ones.
module smi_responder
  import smi_pkg::*;
#(
  parameter int PREAMBLE_LEN = 32
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              mdc_i,
  input  logic              mdio_i,
  output logic              mdio_o,
  output logic              mdio_oe_o,
  input  logic [PHY_W-1:0]  phy_addr_i,
  output logic [REG_W-1:0]  reg_addr_o,
  output logic [DATA_W-1:0] reg_wdata_o,
  output logic              reg_we_o,
  output logic              reg_re_o,
  input  logic [DATA_W-1:0] reg_rdata_i,
  output logic              busy_o,
  output logic              frame_err_o
);

  localparam int CNT_W = $clog2(PREAMBLE_LEN + 1);

`ifdef SMI_RESP_PRE_SUPPRESS_EN
  localparam logic [CNT_W-1:0] PRE_REQ = CNT_W'(1);
`else
  localparam logic [CNT_W-1:0] PRE_REQ = CNT_W'(PREAMBLE_LEN);
`endif

  logic mdc_lvl, mdc_rise, mdc_fall;
  logic mdio_lvl, mdio_rise, mdio_fall;

  smi_sync_edge u_sync_mdc (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .d_i    (mdc_i),
    .q_o    (mdc_lvl),
    .rise_o (mdc_rise),
    .fall_o (mdc_fall)
  );

  smi_sync_edge u_sync_mdio (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .d_i    (mdio_i),
    .q_o    (mdio_lvl),
    .rise_o (mdio_rise),
    .fall_o (mdio_fall)
  );

  // Only the MDC edges and the MDIO level are needed by the frame logic
  logic unused_sync;
  assign unused_sync = &{1'b0, mdc_lvl, mdio_rise, mdio_fall};

  smi_state_e        state_q, state_d;
  logic [CNT_W-1:0]  pre_cnt_q, pre_cnt_d;
  logic [BCNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic [DATA_W-1:0] rd_sh_q, rd_sh_d;
  logic              is_read_q, is_read_d;
  logic              match_q, match_d;
  logic              mdio_q, mdio_d;
  logic              oe_q, oe_d;
  logic [REG_W-1:0]  reg_addr_q, reg_addr_d;
  logic [DATA_W-1:0] reg_wdata_q, reg_wdata_d;
  logic              we_q, we_d;
  logic              re_q, re_d;
  logic              load_q, load_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;

  logic              bit_in;
  logic [DATA_W-1:0] sh_in;
  logic [1:0]        opcode;

  // Next-state, shift and output decode for the Clause-22 frame
  always_comb begin
    state_d     = state_q;
    pre_cnt_d   = pre_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    sh_d        = sh_q;
    rd_sh_d     = rd_sh_q;
    is_read_d   = is_read_q;
    match_d     = match_q;
    mdio_d      = mdio_q;
    oe_d        = oe_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    we_d        = 1'b0;
    re_d        = 1'b0;
    err_d       = 1'b0;
    load_d      = re_q;
    bit_in      = mdio_lvl;
    sh_in       = {sh_q[DATA_W-2:0], mdio_lvl};
    opcode      = {sh_q[0], mdio_lvl};

    // Host read data is valid the cycle after the read strobe
    if (load_q) rd_sh_d = reg_rdata_i;

    case (state_q)
      S_PRE: begin
        if (mdc_rise) begin
          if (bit_in) begin
            if (pre_cnt_q < PRE_REQ) pre_cnt_d = pre_cnt_q + 1'b1;
          end else begin
            pre_cnt_d = '0;
            if (pre_cnt_q >= PRE_REQ) state_d = S_ST;
          end
        end
      end
      S_ST: begin
        if (mdc_rise) begin
          bit_cnt_d = '0;
          if (bit_in) begin
            state_d = S_OP;
          end else begin
            err_d     = 1'b1;
            pre_cnt_d = '0;
            state_d   = S_PRE;
          end
        end
      end
      S_OP: begin
        if (mdc_rise) begin
          sh_d = sh_in;
          if (bit_cnt_q == BCNT_W'(1)) begin
            bit_cnt_d = '0;
            if (opcode == OP_READ) begin
              is_read_d = 1'b1;
              state_d   = S_PHYAD;
            end else if (opcode == OP_WRITE) begin
              is_read_d = 1'b0;
              state_d   = S_PHYAD;
            end else begin
              err_d     = 1'b1;
              pre_cnt_d = '0;
              state_d   = S_PRE;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      S_PHYAD: begin
        if (mdc_rise) begin
          sh_d = sh_in;
          if (bit_cnt_q == BCNT_W'(PHY_W - 1)) begin
            bit_cnt_d = '0;
            match_d   = (sh_in[PHY_W-1:0] == phy_addr_i);
            state_d   = S_REGAD;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      S_REGAD: begin
        if (mdc_rise) begin
          sh_d = sh_in;
          if (bit_cnt_q == BCNT_W'(REG_W - 1)) begin
            bit_cnt_d  = '0;
            reg_addr_d = sh_in[REG_W-1:0];
            if (match_q) begin
              re_d    = is_read_q;
              state_d = S_TA;
            end else begin
              state_d = S_SKIP;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      S_TA: begin
        if (mdc_rise) begin
          if (bit_cnt_q == BCNT_W'(TA_BITS - 1)) begin
            bit_cnt_d = '0;
            state_d   = is_read_q ? S_RDATA : S_WDATA;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else if (mdc_fall && is_read_q && (bit_cnt_q == BCNT_W'(1))) begin
          // Master has released the line for the first TA bit; drive the 0
          oe_d   = 1'b1;
          mdio_d = 1'b0;
        end
      end
      S_WDATA: begin
        if (mdc_rise) begin
          sh_d = sh_in;
          if (bit_cnt_q == BCNT_W'(DATA_W - 1)) begin
            bit_cnt_d   = '0;
            reg_wdata_d = sh_in;
            we_d        = 1'b1;
            pre_cnt_d   = '0;
            state_d     = S_PRE;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      S_RDATA: begin
        if (mdc_fall) begin
          if (bit_cnt_q == BCNT_W'(DATA_W)) begin
            // D0 has been sampled by the master: release the line
            oe_d      = 1'b0;
            mdio_d    = 1'b1;
            bit_cnt_d = '0;
            pre_cnt_d = '0;
            state_d   = S_PRE;
          end else begin
            mdio_d    = rd_sh_q[DATA_W-1];
            rd_sh_d   = {rd_sh_q[DATA_W-2:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      S_SKIP: begin
        if (mdc_rise) begin
          if (bit_cnt_q == BCNT_W'(SKIP_BITS - 1)) begin
            bit_cnt_d = '0;
            pre_cnt_d = '0;
            state_d   = S_PRE;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        pre_cnt_d = '0;
        bit_cnt_d = '0;
        state_d   = S_PRE;
      end
    endcase

    busy_d = (state_d != S_PRE);
  end

  // Control and output registers
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= S_PRE;
      pre_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      is_read_q   <= 1'b0;
      match_q     <= 1'b0;
      mdio_q      <= 1'b1;
      oe_q        <= 1'b0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      we_q        <= 1'b0;
      re_q        <= 1'b0;
      load_q      <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pre_cnt_q   <= pre_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      is_read_q   <= is_read_d;
      match_q     <= match_d;
      mdio_q      <= mdio_d;
      oe_q        <= oe_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      we_q        <= we_d;
      re_q        <= re_d;
      load_q      <= load_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
    end
  end

  // Frame shift registers (pure datapath, no reset needed)
  always_ff @(posedge clk_i) begin
    sh_q    <= sh_d;
    rd_sh_q <= rd_sh_d;
  end

  assign mdio_o      = mdio_q;
  assign mdio_oe_o   = oe_q;
  assign reg_addr_o  = reg_addr_q;
  assign reg_wdata_o = reg_wdata_q;
  assign reg_we_o    = we_q;
  assign reg_re_o    = re_q;
  assign busy_o      = busy_q;
  assign frame_err_o = err_q;

endmodule

// File: tb/tb_smi_responder.sv
// Testbench for smi_responder: bit-bangs Clause-22 frames as an SMI master,
// emulates the host register port and compares against a frame-level model.
module tb_smi_responder;

  localparam int PRE_LEN = 32;
`ifdef SMI_RESP_PRE_SUPPRESS_EN
  localparam int PRE_MIN = 1;
`else
  localparam int PRE_MIN = PRE_LEN;
`endif

  localparam int K_NONE  = 0;
  localparam int K_WRITE = 1;
  localparam int K_READ  = 2;
  localparam int K_ERR   = 3;

  logic        clk = 1'b0;
  logic        rstn;
  logic        mdc;
  logic        mdio_line;
  logic        m_oe;
  logic        m_val;
  logic        mdio_o;
  logic        mdio_oe_o;
  logic [4:0]  phy_addr;
  logic [4:0]  reg_addr_o;
  logic [15:0] reg_wdata_o;
  logic        reg_we_o;
  logic        reg_re_o;
  logic [15:0] reg_rdata;
  logic        busy_o;
  logic        frame_err_o;

  int vectors = 0;
  int miscompares = 0;

  // Monitor state
  int          we_cnt = 0;
  int          re_cnt = 0;
  int          err_cnt = 0;
  bit          oe_seen = 1'b0;
  logic [4:0]  we_addr = '0;
  logic [15:0] we_data = '0;
  logic [4:0]  re_addr = '0;
  logic        re_prev = 1'b0;
  logic [15:0] rd_val = '0;

  always #5 clk = ~clk;

  // Open-drain style bus with pull-up
  assign mdio_line = mdio_oe_o ? mdio_o : (m_oe ? m_val : 1'b1);

  smi_responder #(.PREAMBLE_LEN(PRE_LEN)) dut (
    .clk_i       (clk),
    .rstn_i      (rstn),
    .mdc_i       (mdc),
    .mdio_i      (mdio_line),
    .mdio_o      (mdio_o),
    .mdio_oe_o   (mdio_oe_o),
    .phy_addr_i  (phy_addr),
    .reg_addr_o  (reg_addr_o),
    .reg_wdata_o (reg_wdata_o),
    .reg_we_o    (reg_we_o),
    .reg_re_o    (reg_re_o),
    .reg_rdata_i (reg_rdata),
    .busy_o      (busy_o),
    .frame_err_o (frame_err_o)
  );

  // Strobe / drive monitor
  always @(negedge clk) begin
    if (reg_we_o) begin
      we_cnt++;
      we_addr = reg_addr_o;
      we_data = reg_wdata_o;
    end
    if (reg_re_o) begin
      re_cnt++;
      re_addr = reg_addr_o;
    end
    if (frame_err_o) err_cnt++;
    if (mdio_oe_o) oe_seen = 1'b1;
  end

  // Host: read data valid only in the cycle after the read strobe
  always @(negedge clk) begin
    reg_rdata = re_prev ? rd_val : 16'($urandom);
    re_prev   = reg_re_o;
  end

  function automatic int model_kind(input int pre, input bit [1:0] op,
                                    input bit [4:0] phy, input bit [4:0] own);
    if (pre < PRE_MIN) return K_NONE;
    if (op != 2'b10 && op != 2'b01) return K_ERR;
    if (phy != own) return K_NONE;
    return (op == 2'b10) ? K_READ : K_WRITE;
  endfunction

  task automatic clk_wait(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One MDC period: set the line while MDC is low, sample at the rising edge
  task automatic mdc_bit(input bit drv, input bit val, output bit smp);
    m_oe  = drv;
    m_val = val;
    clk_wait(4);
    mdc = 1'b1;
    smp = mdio_line;
    clk_wait(4);
    mdc = 1'b0;
  endtask

  task automatic send_frame(input int pre, input bit [1:0] op, input bit [4:0] phy,
                            input bit [4:0] ra, input bit [15:0] wd,
                            input bit short_frame, input int abort_bit,
                            output bit [15:0] rbits, output bit ta1, output bit ta2,
                            output bit aborted);
    bit s;
    rbits = '0; ta1 = 1'b0; ta2 = 1'b0; aborted = 1'b0;
    for (int i = 0; i < pre; i++) mdc_bit(1'b1, 1'b1, s);
    mdc_bit(1'b1, 1'b0, s);
    mdc_bit(1'b1, 1'b1, s);
    mdc_bit(1'b1, op[1], s);
    mdc_bit(1'b1, op[0], s);
    if (!short_frame) begin
      for (int i = 4; i >= 0; i--) mdc_bit(1'b1, phy[i], s);
      for (int i = 4; i >= 0; i--) mdc_bit(1'b1, ra[i], s);
      if (op == 2'b10) begin
        mdc_bit(1'b0, 1'b0, ta1);
        mdc_bit(1'b0, 1'b0, ta2);
        for (int i = 15; i >= 0; i--) begin
          if (i == abort_bit) begin
            clk_wait(4);
            aborted = 1'b1;
            return;
          end
          mdc_bit(1'b0, 1'b0, s);
          rbits[i] = s;
        end
      end else begin
        mdc_bit(1'b1, 1'b1, s);
        mdc_bit(1'b1, 1'b0, s);
        for (int i = 15; i >= 0; i--) mdc_bit(1'b1, wd[i], s);
      end
    end
    m_oe  = 1'b1;
    m_val = 1'b1;
    clk_wait(6);
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    clk_wait(3);
    vectors++; if (mdio_o !== 1'b1) begin miscompares++; $display("FAIL rst_mdio_o: got %b expected 1", mdio_o); end
    vectors++; if (mdio_oe_o !== 1'b0) begin miscompares++; $display("FAIL rst_mdio_oe: got %b expected 0", mdio_oe_o); end
    vectors++; if (reg_addr_o !== 5'd0) begin miscompares++; $display("FAIL rst_reg_addr: got %h expected 0", reg_addr_o); end
    vectors++; if (reg_wdata_o !== 16'd0) begin miscompares++; $display("FAIL rst_reg_wdata: got %h expected 0", reg_wdata_o); end
    vectors++; if ({reg_we_o, reg_re_o, busy_o, frame_err_o} !== 4'b0) begin
      miscompares++; $display("FAIL rst_strobes: got %b expected 0000", {reg_we_o, reg_re_o, busy_o, frame_err_o});
    end
    rstn = 1'b1;
    clk_wait(4);
  endtask

  task automatic do_write(input string nm, input int pre, input bit [4:0] phy,
                          input bit [4:0] ra, input bit [15:0] wd, input int exp_we);
    int we0, re0;
    bit [15:0] rb; bit t1, t2, ab;
    we0 = we_cnt; re0 = re_cnt; oe_seen = 1'b0;
    send_frame(pre, 2'b01, phy, ra, wd, 1'b0, -1, rb, t1, t2, ab);
    vectors++; if (we_cnt - we0 !== exp_we) begin miscompares++; $display("FAIL %s we_count: got %0d expected %0d", nm, we_cnt - we0, exp_we); end
    vectors++; if (re_cnt - re0 !== 0) begin miscompares++; $display("FAIL %s re_count: got %0d expected 0", nm, re_cnt - re0); end
    vectors++; if (oe_seen !== 1'b0) begin miscompares++; $display("FAIL %s oe_driven: got 1 expected 0", nm); end
    if (exp_we == 1) begin
      vectors++; if (we_addr !== ra) begin miscompares++; $display("FAIL %s we_addr: got %h expected %h", nm, we_addr, ra); end
      vectors++; if (we_data !== wd) begin miscompares++; $display("FAIL %s we_data: got %h expected %h", nm, we_data, wd); end
      vectors++; if (reg_wdata_o !== wd) begin miscompares++; $display("FAIL %s reg_wdata_o: got %h expected %h", nm, reg_wdata_o, wd); end
    end
    vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("FAIL %s busy_after: got %b expected 0", nm, busy_o); end
  endtask

  task automatic do_read(input string nm, input bit [4:0] phy, input bit [4:0] ra,
                         input bit [15:0] val, input int exp_re);
    int re0, we0;
    bit [15:0] rb; bit t1, t2, ab;
    re0 = re_cnt; we0 = we_cnt; oe_seen = 1'b0; rd_val = val;
    send_frame(PRE_LEN, 2'b10, phy, ra, 16'h0, 1'b0, -1, rb, t1, t2, ab);
    vectors++; if (re_cnt - re0 !== exp_re) begin miscompares++; $display("FAIL %s re_count: got %0d expected %0d", nm, re_cnt - re0, exp_re); end
    vectors++; if (we_cnt - we0 !== 0) begin miscompares++; $display("FAIL %s we_count: got %0d expected 0", nm, we_cnt - we0); end
    vectors++; if (t1 !== 1'b1) begin miscompares++; $display("FAIL %s ta_bit1: got %b expected 1", nm, t1); end
    if (exp_re == 1) begin
      vectors++; if (re_addr !== ra) begin miscompares++; $display("FAIL %s re_addr: got %h expected %h", nm, re_addr, ra); end
      vectors++; if (t2 !== 1'b0) begin miscompares++; $display("FAIL %s ta_bit2: got %b expected 0", nm, t2); end
      vectors++; if (rb !== val) begin miscompares++; $display("FAIL %s read_bits: got %h expected %h", nm, rb, val); end
    end else begin
      vectors++; if (oe_seen !== 1'b0) begin miscompares++; $display("FAIL %s oe_driven: got 1 expected 0", nm); end
    end
    vectors++; if (mdio_oe_o !== 1'b0) begin miscompares++; $display("FAIL %s oe_after: got %b expected 0", nm, mdio_oe_o); end
    vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("FAIL %s busy_after: got %b expected 0", nm, busy_o); end
  endtask

  task automatic test_write;
    phy_addr = 5'd3;
    do_write("write", PRE_LEN, 5'd3, 5'd5, 16'hA5C3, 1);
    vectors++; if (reg_addr_o !== 5'd5) begin miscompares++; $display("FAIL write reg_addr_o: got %h expected 05", reg_addr_o); end
  endtask

  task automatic test_read;
    phy_addr = 5'd3;
    do_read("read", 5'd3, 5'd2, 16'h1234, 1);
  endtask

  task automatic test_wrong_phy;
    phy_addr = 5'd3;
    do_read("wrong_phy", 5'd7, 5'd2, 16'h5A5A, 0);
    do_write("after_wrong_phy", PRE_LEN, 5'd3, 5'd9, 16'h0F0F, 1);
  endtask

  task automatic test_short_preamble;
    phy_addr = 5'd3;
`ifdef SMI_RESP_PRE_SUPPRESS_EN
    do_write("suppressed_pre", 1, 5'd3, 5'd11, 16'hC001, 1);
`else
    do_write("short_pre", PRE_LEN - 1, 5'd3, 5'd11, 16'hC001, 0);
`endif
    do_write("after_short_pre", PRE_LEN, 5'd3, 5'd12, 16'h7E81, 1);
  endtask

  task automatic test_bad_opcode;
    int e0, w0, r0;
    bit [15:0] rb; bit t1, t2, ab;
    phy_addr = 5'd3;
    e0 = err_cnt; w0 = we_cnt; r0 = re_cnt;
    send_frame(PRE_LEN, 2'b11, 5'd3, 5'd1, 16'h0, 1'b1, -1, rb, t1, t2, ab);
    vectors++; if (err_cnt - e0 !== 1) begin miscompares++; $display("FAIL op11 err_pulses: got %0d expected 1", err_cnt - e0); end
    vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("FAIL op11 busy: got %b expected 0", busy_o); end
    vectors++; if ((we_cnt - w0) + (re_cnt - r0) !== 0) begin
      miscompares++; $display("FAIL op11 strobes: got %0d expected 0", (we_cnt - w0) + (re_cnt - r0));
    end
    e0 = err_cnt;
    send_frame(PRE_LEN, 2'b00, 5'd3, 5'd1, 16'h0, 1'b1, -1, rb, t1, t2, ab);
    vectors++; if (err_cnt - e0 !== 1) begin miscompares++; $display("FAIL op00 err_pulses: got %0d expected 1", err_cnt - e0); end
  endtask

  task automatic test_random;
    int kind, pre, w0, r0, e0;
    bit [1:0] op; bit [4:0] own, phy, ra; bit [15:0] wd, rv, rb;
    bit t1, t2, ab;
    for (int n = 0; n < 10; n++) begin
      own = 5'($urandom);
      phy = ($urandom_range(0, 2) != 0) ? own : 5'($urandom);
      op  = 2'($urandom);
      ra  = 5'($urandom);
      wd  = 16'($urandom);
      rv  = 16'($urandom);
      pre = PRE_LEN + $urandom_range(0, 3);
      kind = model_kind(pre, op, phy, own);
      phy_addr = own; rd_val = rv;
      w0 = we_cnt; r0 = re_cnt; e0 = err_cnt; oe_seen = 1'b0;
      send_frame(pre, op, phy, ra, wd, kind == K_ERR, -1, rb, t1, t2, ab);
      vectors++; if (we_cnt - w0 !== ((kind == K_WRITE) ? 1 : 0)) begin
        miscompares++; $display("FAIL rnd%0d we_count: got %0d expected %0d", n, we_cnt - w0, (kind == K_WRITE) ? 1 : 0);
      end
      vectors++; if (re_cnt - r0 !== ((kind == K_READ) ? 1 : 0)) begin
        miscompares++; $display("FAIL rnd%0d re_count: got %0d expected %0d", n, re_cnt - r0, (kind == K_READ) ? 1 : 0);
      end
      vectors++; if (err_cnt - e0 !== ((kind == K_ERR) ? 1 : 0)) begin
        miscompares++; $display("FAIL rnd%0d err_count: got %0d expected %0d", n, err_cnt - e0, (kind == K_ERR) ? 1 : 0);
      end
      if (kind == K_WRITE) begin
        vectors++; if ({we_addr, we_data} !== {ra, wd}) begin
          miscompares++; $display("FAIL rnd%0d write_payload: got %h/%h expected %h/%h", n, we_addr, we_data, ra, wd);
        end
      end
      if (kind == K_READ) begin
        vectors++; if (rb !== rv) begin miscompares++; $display("FAIL rnd%0d read_bits: got %h expected %h", n, rb, rv); end
      end else begin
        vectors++; if (oe_seen !== 1'b0) begin miscompares++; $display("FAIL rnd%0d oe_driven: got 1 expected 0", n); end
      end
    end
  endtask

  task automatic test_reset_mid_read;
    bit [15:0] rb; bit t1, t2, ab;
    phy_addr = 5'd3; rd_val = 16'hBEEF;
    send_frame(PRE_LEN, 2'b10, 5'd3, 5'd9, 16'h0, 1'b0, 8, rb, t1, t2, ab);
    vectors++; if (mdio_oe_o !== 1'b1) begin miscompares++; $display("FAIL midread oe_before: got %b expected 1", mdio_oe_o); end
    vectors++; if (busy_o !== 1'b1) begin miscompares++; $display("FAIL midread busy_before: got %b expected 1", busy_o); end
    #2 rstn = 1'b0;
    #1;
    vectors++; if (mdio_oe_o !== 1'b0) begin miscompares++; $display("FAIL midread oe_in_reset: got %b expected 0", mdio_oe_o); end
    vectors++; if (mdio_o !== 1'b1) begin miscompares++; $display("FAIL midread mdio_in_reset: got %b expected 1", mdio_o); end
    vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("FAIL midread busy_in_reset: got %b expected 0", busy_o); end
    clk_wait(3);
    m_oe = 1'b1; m_val = 1'b1;
    rstn = 1'b1;
    clk_wait(4);
    do_write("post_reset_write", PRE_LEN, 5'd3, 5'd14, 16'h3C96, 1);
    do_read("post_reset_read", 5'd3, 5'd9, 16'hBEEF, 1);
  endtask

  initial begin
    rstn = 1'b0; mdc = 1'b0; m_oe = 1'b1; m_val = 1'b1; phy_addr = 5'd3;
    test_reset();
    test_write();
    test_read();
    test_wrong_phy();
    test_short_preamble();
    test_bad_opcode();
    test_random();
    test_reset_mid_read();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
